// File: rtl/bram_row_sched_pkg.sv
// -----------------------------------------------------------------------------
// bram_row_sched_pkg
//   Shared definitions for the disparity-map row scheduler:
//   - default frame geometry (IMG_W, IMG_H, NUM_ROWS)
//   - the all-bytes write-enable constant for BRAM port A
//   - FSM state encoding
//   - slot_base(): start address of a row slot, built from additions only
// -----------------------------------------------------------------------------
package bram_row_sched_pkg;

  localparam int IMG_W_DEF    = 640;
  localparam int IMG_H_DEF    = 480;
  localparam int NUM_ROWS_DEF = 7;

  localparam logic [3:0] WE_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME  = 3'd1,
    ST_KICK   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOAD   = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  // Word address of the first pixel of a slot (slot * img_w) as a sum of
  // img_w terms, so no multiplier is inferred.
  function automatic logic [31:0] slot_base(input logic [2:0] slot,
                                            input int unsigned img_w);
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = 0; i < 7; i++) begin
      if (3'(i) < slot) begin
        acc = acc + 32'(img_w);
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/bram_row_sched_addr_gen.sv
// -----------------------------------------------------------------------------
// bram_row_addr_gen
//   Running BRAM port A address for the circular row window.
//   ptr = slot*IMG_W + col, kept incrementally: col wraps IMG_W-1 -> 0 and
//   advances slot; slot wraps NUM_ROWS-1 -> 0 and ptr returns to 0.
// Ports:
//   clkb, reset       clock, async active-high reset
//   clear             zero all counters (frame start)
//   step              one pixel accepted: advance col/slot/ptr
//   load, load_slot   realign counters to the start of slot load_slot
//   addr              current word address (ptr)
//   row_last          col is on the last pixel of the row
//   slot_last         slot is the last slot of the window
// -----------------------------------------------------------------------------
module bram_row_addr_gen
  import bram_row_sched_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int ADDR_W   = 32
) (
  input  logic              clkb,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  input  logic              load,
  input  logic [2:0]        load_slot,
  output logic [ADDR_W-1:0] addr,
  output logic              row_last,
  output logic              slot_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [CW-1:0]     col_q, col_d;
  logic [2:0]        slot_q, slot_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  assign addr      = ptr_q;
  assign row_last  = (col_q == CW'(IMG_W - 1));
  assign slot_last = (slot_q == 3'(NUM_ROWS - 1));

  // Next-value logic for the col/slot/ptr counters.
  always_comb begin
    col_d  = col_q;
    slot_d = slot_q;
    ptr_d  = ptr_q;
    if (clear) begin
      col_d  = '0;
      slot_d = 3'd0;
      ptr_d  = '0;
    end else if (load) begin
      col_d  = '0;
      slot_d = load_slot;
      ptr_d  = ADDR_W'(slot_base(load_slot, IMG_W));
    end else if (step) begin
      if (row_last) begin
        col_d = '0;
        if (slot_last) begin
          slot_d = 3'd0;
          ptr_d  = '0;
        end else begin
          slot_d = slot_q + 3'd1;
          ptr_d  = ptr_q + ADDR_W'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
        ptr_d = ptr_q + ADDR_W'(1);
      end
    end else begin
      col_d  = col_q;
      slot_d = slot_q;
      ptr_d  = ptr_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clkb or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      slot_q <= 3'd0;
      ptr_q  <= '0;
    end else begin
      col_q  <= col_d;
      slot_q <= slot_d;
      ptr_q  <= ptr_d;
    end
  end

endmodule

// File: rtl/bram_row_sched.sv
// -----------------------------------------------------------------------------
// bram_row_sched
//   Frame sequencer for the disparity-map BRAM and the bram_dm engine.
//   Primes a NUM_ROWS-row circular window from the pixel stream, kicks
//   bram_dm, and after every dm_done overwrites the oldest slot with the next
//   image row and kicks again, until IMG_H-NUM_ROWS+1 rows are produced.
// Ports:
//   clkb, reset              clock, async active-high reset
//   start, cfg_window        frame start (IDLE only), window size to latch
//   pix_valid/pix_data/pix_ready   input pixel stream handshake
//   ena, wea, addra, dina    BRAM port A write (1 cycle after accept)
//   go, window, base_slot    kick and context for bram_dm
//   dm_done                  bram_dm finished a row (honoured in WAIT only)
//   frame_done               one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module bram_row_sched
  import bram_row_sched_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clkb,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        cfg_window,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              ena,
  output logic [3:0]        wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              go,
  output logic [2:0]        window,
  output logic [2:0]        base_slot,
  input  logic              dm_done,
  output logic              frame_done
);

  localparam int RW = $clog2(IMG_H + 2);

  state_e            state_q, state_d;
  logic [RW-1:0]     rows_done_q, rows_done_d;
  logic [2:0]        window_q, window_d;
  logic [2:0]        base_slot_q, base_slot_d;
  logic              pix_ready_q, pix_ready_d;
  logic              go_q, go_d;
  logic              frame_done_q, frame_done_d;
  logic              ena_q, ena_d;
  logic [3:0]        wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;

  logic              accept;
  logic              ag_clear, ag_load;
  logic [ADDR_W-1:0] ag_addr;
  logic              ag_row_last, ag_slot_last;

  // pix_ready is a flop, so the handshake is a pure register AND input.
  assign accept = pix_valid && pix_ready_q;

  bram_row_addr_gen #(
    .IMG_W    (IMG_W),
    .NUM_ROWS (NUM_ROWS),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clkb      (clkb),
    .reset     (reset),
    .clear     (ag_clear),
    .step      (accept),
    .load      (ag_load),
    .load_slot (base_slot_q),
    .addr      (ag_addr),
    .row_last  (ag_row_last),
    .slot_last (ag_slot_last)
  );

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d     = state_q;
    rows_done_d = rows_done_q;
    window_d    = window_q;
    base_slot_d = base_slot_q;
    ag_clear    = 1'b0;
    ag_load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          window_d    = cfg_window;
          base_slot_d = 3'd0;
          rows_done_d = '0;
          ag_clear    = 1'b1;
          state_d     = ST_PRIME;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRIME: begin
        if (accept && ag_row_last && ag_slot_last) begin
          state_d = ST_KICK;
        end else begin
          state_d = ST_PRIME;
        end
      end
      ST_KICK: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Leaving WAIT on the first dm_done makes a held level count once.
        if (dm_done) begin
          rows_done_d = rows_done_q + RW'(1);
          if (rows_done_d == RW'(IMG_H - NUM_ROWS + 1)) begin
            state_d = ST_FINISH;
          end else begin
            ag_load = 1'b1;
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_LOAD: begin
        if (accept && ag_row_last) begin
          base_slot_d = (base_slot_q == 3'(NUM_ROWS - 1)) ? 3'd0 : base_slot_q + 3'd1;
          state_d     = ST_KICK;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs decoded from the next state so they align with state_q.
    pix_ready_d  = (state_d == ST_PRIME) || (state_d == ST_LOAD);
    go_d         = (state_d == ST_KICK);
    frame_done_d = (state_d == ST_FINISH);

    ena_d   = accept;
    wea_d   = accept ? WE_ALL : 4'h0;
    addra_d = accept ? ag_addr : addra_q;
    dina_d  = accept ? pix_data : dina_q;
  end

  // State, counters and output registers.
  always_ff @(posedge clkb or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rows_done_q  <= '0;
      window_q     <= 3'd0;
      base_slot_q  <= 3'd0;
      pix_ready_q  <= 1'b0;
      go_q         <= 1'b0;
      frame_done_q <= 1'b0;
      ena_q        <= 1'b0;
      wea_q        <= 4'h0;
      addra_q      <= '0;
      dina_q       <= '0;
    end else begin
      state_q      <= state_d;
      rows_done_q  <= rows_done_d;
      window_q     <= window_d;
      base_slot_q  <= base_slot_d;
      pix_ready_q  <= pix_ready_d;
      go_q         <= go_d;
      frame_done_q <= frame_done_d;
      ena_q        <= ena_d;
      wea_q        <= wea_d;
      addra_q      <= addra_d;
      dina_q       <= dina_d;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign go         = go_q;
  assign frame_done = frame_done_q;
  assign window     = window_q;
  assign base_slot  = base_slot_q;
  assign ena        = ena_q;
  assign wea        = wea_q;
  assign addra      = addra_q;
  assign dina       = dina_q;

endmodule

// File: tb/tb_bram_row_sched.sv
// -----------------------------------------------------------------------------
// tb_bram_row_sched
//   Self-checking bench for bram_row_sched with a small frame geometry.
//   The reference model is a queue of expected BRAM writes derived from the
//   frame rules: prime pixel k -> address k; load L -> slot L mod NUM_ROWS.
// -----------------------------------------------------------------------------
module tb_bram_row_sched;

  localparam int IMG_W    = 4;
  localparam int IMG_H    = 16;
  localparam int NR       = 7;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int ROWS_OUT = IMG_H - NR + 1;

  logic          clkb = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    cfg_window = 3'd0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic          dm_done = 1'b0;
  logic          pix_ready, ena, go, frame_done;
  logic [3:0]    wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [2:0]    window, base_slot;

  bram_row_sched #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_ROWS(NR), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clkb(clkb), .reset(reset), .start(start), .cfg_window(cfg_window),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .go(go),
    .window(window), .base_slot(base_slot), .dm_done(dm_done),
    .frame_done(frame_done)
  );

  always #5 clkb = ~clkb;

  int checks = 0;
  int errors = 0;
  int go_cnt = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t wq[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every enabled write must be the next expected one.
  always @(negedge clkb) begin
    wr_t e;
    if (go === 1'b1) go_cnt++;
    if (ena === 1'b1) begin
      check_val("write_expected", 64'(ena), 64'(wq.size() != 0));
      if (wq.size() != 0) begin
        e = wq.pop_front();
        check_val("addra", 64'(addra), 64'(e.a));
        check_val("dina", 64'(dina), 64'(e.d));
        check_val("wea_on", 64'(wea), 64'h0F);
      end
    end else begin
      check_val("wea_idle", 64'(wea), 64'h0);
    end
  end

  task automatic step();
    @(posedge clkb);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_ready"}, 64'(pix_ready), 64'h0);
    check_val({tag, "_ena"}, 64'(ena), 64'h0);
    check_val({tag, "_wea"}, 64'(wea), 64'h0);
    check_val({tag, "_addra"}, 64'(addra), 64'h0);
    check_val({tag, "_dina"}, 64'(dina), 64'h0);
    check_val({tag, "_go"}, 64'(go), 64'h0);
    check_val({tag, "_frame_done"}, 64'(frame_done), 64'h0);
    check_val({tag, "_window"}, 64'(window), 64'h0);
    check_val({tag, "_base_slot"}, 64'(base_slot), 64'h0);
  endtask

  // Push n pixels into slot `slot`; abort_after >= 0 resets after that many.
  task automatic feed(input int n, input int slot, input bit dense, input bit alt,
                      input bit idx_data, input logic [31:0] dbase,
                      input int abort_after, output bit aborted);
    bit v;
    int i;
    int cyc;
    wr_t e;
    v = 1'b0;
    i = 0;
    cyc = 0;
    aborted = 1'b0;
    while (i < n) begin
      if (i == abort_after) begin
        pix_valid = 1'b0;
        dm_done = 1'b0;
        #1 reset = 1'b1;
        #1 check_zero_outputs("abort");
        wq.delete();
        step();
        reset = 1'b0;
        step();
        aborted = 1'b1;
        return;
      end
      if (cyc > 64 * n) begin
        check_val("feed_budget", 64'(i), 64'(n));
        break;
      end
      check_val("pix_ready_on", 64'(pix_ready), 64'h1);
      if (dense) v = 1'b1;
      else if (alt) v = ~v;
      else v = 1'($urandom_range(0, 1));
      pix_valid = v;
      if (v) begin
        pix_data = idx_data ? dbase + 32'(i) : $urandom;
        e.a = 32'(slot * IMG_W + i);
        e.d = pix_data;
        wq.push_back(e);
        i++;
      end
      step();
      cyc++;
    end
    pix_valid = 1'b0;
  endtask

  task automatic run_frame(input int win, input bit first,
                           input int abort_load, input int abort_after);
    bit ab;
    bit hold2;
    int base;
    check_val("idle_ready", 64'(pix_ready), 64'h0);
    go_cnt = 0;
    cfg_window = 3'(win);
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_window = 3'($urandom);
    check_val("window_latched", 64'(window), 64'(win));
    check_val("prime_ready", 64'(pix_ready), 64'h1);
    feed(NR * IMG_W, 0, first, 1'b0, first, 32'h0, -1, ab);
    check_val("prime_go", 64'(go), 64'h1);
    check_val("prime_ready_off", 64'(pix_ready), 64'h0);
    check_val("prime_base", 64'(base_slot), 64'h0);
    for (int r = 1; r <= ROWS_OUT; r++) begin
      base = (r - 1) % NR;
      step();
      check_val("go_single", 64'(go), 64'h0);
      repeat ($urandom_range(0, 3)) begin
        step();
        check_val("wait_go", 64'(go), 64'h0);
        check_val("wait_ready", 64'(pix_ready), 64'h0);
        check_val("wait_base", 64'(base_slot), 64'(base));
      end
      dm_done = 1'b1;
      hold2 = (r < ROWS_OUT) && (1'($urandom_range(0, 1)) == 1'b1);
      step();
      if (hold2) step();
      dm_done = 1'b0;
      if (r == ROWS_OUT) begin
        check_val("frame_done", 64'(frame_done), 64'h1);
        check_val("finish_ready", 64'(pix_ready), 64'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("frame_done_single", 64'(frame_done), 64'h0);
        check_val("start_in_finish_ignored", 64'(pix_ready), 64'h0);
        dm_done = 1'b1;
        repeat (4) begin
          step();
          check_val("idle_done_no_go", 64'(go), 64'h0);
          check_val("idle_done_ready", 64'(pix_ready), 64'h0);
        end
        dm_done = 1'b0;
        step();
        check_val("go_count", 64'(go_cnt), 64'(ROWS_OUT));
        check_val("writes_drained", 64'(wq.size()), 64'h0);
      end else begin
        feed(IMG_W, base, 1'b0, first, first, 32'hDEAD0000,
             (r - 1 == abort_load) ? abort_after : -1, ab);
        if (ab) return;
        check_val("load_go", 64'(go), 64'h1);
        check_val("load_base", 64'(base_slot), 64'(r % NR));
        check_val("load_ready_off", 64'(pix_ready), 64'h0);
        check_val("load_no_frame_done", 64'(frame_done), 64'h0);
      end
    end
  endtask

  initial begin
    #12;
    check_zero_outputs("reset");
    step();
    reset = 1'b0;
    step();
    check_zero_outputs("post_reset");
    // Dense prime with index data, alternating-valid loads with 0xDEAD0000+i.
    run_frame(3, 1'b1, -1, -1);
    // Random traffic, reset in the middle of the third load.
    run_frame(5, 1'b0, 2, 3);
    check_zero_outputs("after_abort");
    // New frame after the abort must re-prime from address 0.
    run_frame(2 * $urandom_range(0, 3) + 1, 1'b0, -1, -1);
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_row_sched.md
Name: bram_row_sched

Overview:
- Controller that sequences the disparity-map BRAM and the bram_dm engine for a whole frame.
- Accepts a pixel stream and writes it into a circular NUM_ROWS-row window on BRAM port A.
- Pulses go to bram_dm once the window is primed, then waits for done.
- After each done, refills the oldest row slot with the next image row and re-kicks, until all output rows of the frame are produced.

Parameters:
- IMG_W, 640, pixels (32-bit words) per row.
- IMG_H, 480, rows per frame.
- NUM_ROWS, 7, row slots held in BRAM (max window height).
- ADDR_W, 32, BRAM port A address width.
- DATA_W, 32, pixel word width.

Ports:
- clkb  in  1  single clock (also drives BRAM port A and bram_dm).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- cfg_window  in  3  window size; latched on accepted start.
- pix_valid  in  1  input stream valid.
- pix_data  in  DATA_W  input pixel word.
- pix_ready  out  1  controller can accept a pixel.
- ena  out  1  BRAM port A enable.
- wea  out  4  BRAM port A byte write enables.
- addra  out  ADDR_W  BRAM port A word address.
- dina  out  DATA_W  BRAM port A write data.
- go  out  1  one-cycle kick to bram_dm.
- window  out  3  latched window size to bram_dm.
- base_slot  out  3  slot index of the oldest (top) row in the current window.
- dm_done  in  1  bram_dm finished the current row.
- frame_done  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset (async, immediate): state=IDLE. pix_ready, ena, go, frame_done = 0. wea=0, addra=0, dina=0, window=0, base_slot=0. All counters 0.
- Reset mid-operation aborts the frame; BRAM contents are not cleared.
- States: IDLE, PRIME, KICK, WAIT, LOAD, FINISH.
- IDLE: start=1 -> latch cfg_window into window, clear counters, go to PRIME.
- pix_ready=1 only in PRIME and LOAD. It drops in the same cycle as the transition out of those states.
- Write path: an accepted pixel (pix_valid&&pix_ready) registers ena=1, wea=4'hF, addra=ptr, dina=pix_data on the next edge (1-cycle latency).
  - Cycles with no accept register ena=0, wea=0.
  - addra/dina hold their last value.
- Address: ptr = slot*IMG_W + col, kept as a running register.
  - col wraps IMG_W-1 -> 0 and advances slot.
  - slot wraps NUM_ROWS-1 -> 0 with ptr reset to 0 (no multiplier).
- PRIME: accept NUM_ROWS*IMG_W pixels into slots 0..NUM_ROWS-1, then -> KICK.
- KICK: go=1 for exactly one cycle; base_slot is valid and stable from KICK through WAIT. Next state WAIT.
- WAIT: first cycle with dm_done=1 increments rows_done.
  - rows_done == IMG_H-NUM_ROWS+1 -> FINISH.
  - Otherwise -> LOAD.
- dm_done is ignored in every state except WAIT; a level held high only counts once per WAIT entry.
- LOAD: accept IMG_W pixels into slot base_slot (overwrite oldest row), then base_slot = base_slot+1 mod NUM_ROWS, -> KICK.
- FINISH: frame_done=1 for one cycle, -> IDLE. start in the same cycle is ignored.
- No BRAM write occurs outside PRIME/LOAD (+1 latency cycle). bram_dm owns port B exclusively.
- cfg_window is passed through unchanged. Legality (odd, <= NUM_ROWS) is the caller's responsibility.

Decomposition:
- Shared include bram_dm_defs.vh holds:
  - state encodings (localparam);
  - IMG_W, IMG_H, NUM_ROWS defaults;
  - the WE_ALL = 4'hF constant.
- Sub-module bram_row_addr_gen holds the col/slot/ptr counters and wrap logic, with inputs clear, step, load_slot and outputs addr, row_last.
- The FSM and handshake stay in bram_row_sched.

Test Plan:
- Prime: start, cfg_window=3, stream 4480 words of value=index with pix_valid=1 -> addra 0..4479 written with dina=index, ena high 4480 cycles, pix_ready falls after the last accept, single-cycle go 1 cycle later, window=3, base_slot=0.
- Refill: after go, pulse dm_done, stream 640 words 0xDEAD0000+i -> addra 0..639, then go again with base_slot=1; a second done+load writes 640..1279 with base_slot=2.
- Wrap: 7 consecutive done/load cycles -> 7th load writes slot 6 (3840..4479), base_slot returns to 0, next load targets addr 0.
- Backpressure/gaps: toggle pix_valid 1/0 every cycle in LOAD -> ena/wea=0 in gap cycles, addresses contiguous with no skips or duplicates.
- Frame end with IMG_H=9, NUM_ROWS=7, IMG_W=4 -> exactly 3 go pulses, frame_done pulses once after the 3rd dm_done, state IDLE; dm_done held high in IDLE produces no go.
- Reset mid-LOAD (after 100 words) -> all outputs 0 immediately, pix_ready=0; a new start re-primes from addra=0.
